// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel LED PWM generator with shadowed configuration.
// Configuration written through cfg_commit lands in a shadow set and is moved
// into the active set only while idle or at a period boundary, so a running
// period never sees a torn update.
// Optional feature macro: LED_PWM_FADE_EN (per-channel triangular duty fade).
module led_pwm_ctrl #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic [31:0]            cfg_ctrl,
  input  logic [31:0]            cfg_period,
  input  logic [NUM_CH*32-1:0]   cfg_duty,
  input  logic                   cfg_commit,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic [31:0]            status
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [15:0]                   pcnt_q, pcnt_d;
  logic                          pend_q, pend_d;

  logic [CNT_W-1:0]              shd_period_q, shd_period_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  shd_duty_q, shd_duty_d;
  logic                          shd_inv_q, shd_inv_d;
  logic [NUM_CH-1:0]             shd_chen_q, shd_chen_d;

  logic [CNT_W-1:0]              act_period_q, act_period_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  act_duty_q, act_duty_d;
  logic                          act_inv_q, act_inv_d;
  logic [NUM_CH-1:0]             act_chen_q, act_chen_d;

  logic [NUM_CH-1:0]             pwm_q, pwm_d;
  logic [31:0]                   status_q, status_d;

  logic [NUM_CH-1:0][CNT_W-1:0]  eff_duty_s;
  logic                          enable_s;
  logic                          running_s;
  logic                          boundary_s;
  logic                          load_s;
  logic                          unused_cfg_s;

  // Enable is live, never shadowed; upper cfg bits beyond CNT_W are ignored.
  assign enable_s     = cfg_ctrl[0];
  assign running_s    = (state_q != ST_IDLE);
  assign boundary_s   = running_s && (act_period_q != {CNT_W{1'b0}}) &&
                        (cnt_q == (act_period_q - CNT_W'(1)));
  assign load_s       = pend_q && ((state_q == ST_IDLE) || boundary_s);
  assign unused_cfg_s = ^{cfg_ctrl, cfg_period, cfg_duty};

  // State transitions: IDLE/RUN/STOPPING, zero period always parks in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_s && (act_period_q != {CNT_W{1'b0}})) state_d = ST_RUN;
        else                                             state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (act_period_q == {CNT_W{1'b0}}) state_d = ST_IDLE;
        else if (!enable_s)                state_d = ST_STOPPING;
        else                               state_d = ST_RUN;
      end
      ST_STOPPING: begin
        if (act_period_q == {CNT_W{1'b0}}) state_d = ST_IDLE;
        else if (enable_s)                 state_d = ST_RUN;
        else if (boundary_s)               state_d = ST_IDLE;
        else                               state_d = ST_STOPPING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Period counter, boundary count and shadow/active configuration transfer
  always_comb begin
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    pend_d       = pend_q;
    shd_period_d = shd_period_q;
    shd_duty_d   = shd_duty_q;
    shd_inv_d    = shd_inv_q;
    shd_chen_d   = shd_chen_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_inv_d    = act_inv_q;
    act_chen_d   = act_chen_q;

    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) cnt_d = {CNT_W{1'b0}};
    else if (boundary_s)                              cnt_d = {CNT_W{1'b0}};
    else                                              cnt_d = cnt_q + CNT_W'(1);

    if (boundary_s) pcnt_d = pcnt_q + 16'd1;
    else            pcnt_d = pcnt_q;

    // The active set takes the shadow contents as they were before any commit
    // in this same cycle; such a commit waits for the next transfer point.
    if (load_s) begin
      act_period_d = shd_period_q;
      act_duty_d   = shd_duty_q;
      act_inv_d    = shd_inv_q;
      act_chen_d   = shd_chen_q;
    end else begin
      act_period_d = act_period_q;
    end

    if (cfg_commit) begin
      shd_period_d = cfg_period[CNT_W-1:0];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shd_duty_d[ch] = cfg_duty[ch*32 +: CNT_W];
      end
      shd_inv_d  = cfg_ctrl[1];
      shd_chen_d = cfg_ctrl[8 +: NUM_CH];
      pend_d     = 1'b1;
    end else if (load_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

`ifdef LED_PWM_FADE_EN
  logic [NUM_CH-1:0]             shd_fade_q, shd_fade_d;
  logic [NUM_CH-1:0]             act_fade_q, act_fade_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  fade_lvl_q, fade_lvl_d;
  logic [NUM_CH-1:0]             fade_down_q, fade_down_d;

  // Fade enable bits follow the same shadow/active path as the other controls
  always_comb begin
    shd_fade_d = shd_fade_q;
    act_fade_d = act_fade_q;
    if (load_s) act_fade_d = shd_fade_q;
    else        act_fade_d = act_fade_q;
    if (cfg_commit) shd_fade_d = cfg_ctrl[16 +: NUM_CH];
    else            shd_fade_d = shd_fade_q;
  end

  // Triangular ramp: one step per boundary, turning at 0 and at active duty
  always_comb begin
    fade_lvl_d  = fade_lvl_q;
    fade_down_d = fade_down_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!act_fade_q[ch] || (state_q == ST_IDLE) ||
          (act_duty_q[ch] == {CNT_W{1'b0}})) begin
        fade_lvl_d[ch]  = {CNT_W{1'b0}};
        fade_down_d[ch] = 1'b0;
      end else if (boundary_s) begin
        if (!fade_down_q[ch]) begin
          if (({1'b0, fade_lvl_q[ch]} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, act_duty_q[ch]}) begin
            fade_lvl_d[ch]  = act_duty_q[ch];
            fade_down_d[ch] = 1'b1;
          end else begin
            fade_lvl_d[ch]  = fade_lvl_q[ch] + CNT_W'(1);
            fade_down_d[ch] = 1'b0;
          end
        end else begin
          if (fade_lvl_q[ch] <= CNT_W'(1)) begin
            fade_lvl_d[ch]  = {CNT_W{1'b0}};
            fade_down_d[ch] = 1'b0;
          end else if (fade_lvl_q[ch] > act_duty_q[ch]) begin
            fade_lvl_d[ch]  = act_duty_q[ch];
            fade_down_d[ch] = 1'b1;
          end else begin
            fade_lvl_d[ch]  = fade_lvl_q[ch] - CNT_W'(1);
            fade_down_d[ch] = 1'b1;
          end
        end
      end else begin
        fade_lvl_d[ch]  = fade_lvl_q[ch];
        fade_down_d[ch] = fade_down_q[ch];
      end
    end
  end

  // Effective duty: ramp level for fading channels, active duty otherwise
  always_comb begin
    eff_duty_s = act_duty_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (act_fade_q[ch]) eff_duty_s[ch] = fade_lvl_q[ch];
      else                eff_duty_s[ch] = act_duty_q[ch];
    end
  end

  // Fade state registers
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      shd_fade_q  <= {NUM_CH{1'b0}};
      act_fade_q  <= {NUM_CH{1'b0}};
      fade_lvl_q  <= {NUM_CH*CNT_W{1'b0}};
      fade_down_q <= {NUM_CH{1'b0}};
    end else begin
      shd_fade_q  <= shd_fade_d;
      act_fade_q  <= act_fade_d;
      fade_lvl_q  <= fade_lvl_d;
      fade_down_q <= fade_down_d;
    end
  end
`else
  // Without fade support every channel uses its active duty directly
  always_comb begin
    eff_duty_s = act_duty_q;
  end
`endif

  // PWM level per channel and registered status word
  always_comb begin
    pwm_d = {NUM_CH{act_inv_q}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (state_q == ST_IDLE) pwm_d[ch] = act_inv_q;
      else                    pwm_d[ch] = ((cnt_q < eff_duty_s[ch]) & act_chen_q[ch]) ^ act_inv_q;
    end
    status_d = {pcnt_d, 12'd0, state_d, pend_d, (state_d != ST_IDLE)};
  end

  // Core registers; reset returns everything, outputs included, to zero
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      pcnt_q       <= 16'd0;
      pend_q       <= 1'b0;
      shd_period_q <= {CNT_W{1'b0}};
      shd_duty_q   <= {NUM_CH*CNT_W{1'b0}};
      shd_inv_q    <= 1'b0;
      shd_chen_q   <= {NUM_CH{1'b0}};
      act_period_q <= {CNT_W{1'b0}};
      act_duty_q   <= {NUM_CH*CNT_W{1'b0}};
      act_inv_q    <= 1'b0;
      act_chen_q   <= {NUM_CH{1'b0}};
      pwm_q        <= {NUM_CH{1'b0}};
      status_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      pend_q       <= pend_d;
      shd_period_q <= shd_period_d;
      shd_duty_q   <= shd_duty_d;
      shd_inv_q    <= shd_inv_d;
      shd_chen_q   <= shd_chen_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_inv_q    <= act_inv_d;
      act_chen_q   <= act_chen_d;
      pwm_q        <= pwm_d;
      status_q     <= status_d;
    end
  end

  assign pwm_out = pwm_q;
  assign status  = status_q;

endmodule
